geofence_seq: RTL and testbench

Operation sequencer for the geofence datapath. It counts the 7-sample input frame (object point, then receivers 1–6), then issues one operation at a time to the shared arithmetic datapath over a valid/done handshake: accumulator clear, angular sort of the receivers, polygon-area terms, triangle-area terms and the final compare. It then pulses `valid` with the datapath's verdict and re-arms for the next frame.

---
 rtl/geofence_seq.sv | 278 +++++++++++++++++++++++++++
 tb/tb_geofence_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/geofence_seq.sv
// geofence_seq: operation sequencer for the geofence datapath.
// Counts the 7-sample input frame into datapath slots, then issues one op at a
// time (CLR, selection-sort CMP/SWAP, POLY terms, TRI terms, DECIDE) over a
// valid/done handshake, strobes the verdict and re-arms for the next frame.
// All outputs come straight from flops; the op/index flops double as the
// sequencing counters, so what is on the pins is exactly the pending request.
module geofence_seq #(
  parameter int IDX_W = 3,
  parameter int OP_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  output logic             load_en,
  output logic [IDX_W-1:0] load_idx,
  output logic             op_valid,
  output logic [OP_W-1:0]  op,
  output logic [IDX_W-1:0] idx_a,
  output logic [IDX_W-1:0] idx_b,
  input  logic             dp_done,
  input  logic             dp_flag,
  output logic             valid,
  output logic             is_inside
);

  // Sequencer states
  localparam logic [2:0] S_LOAD = 3'd0;
  localparam logic [2:0] S_CLR  = 3'd1;
  localparam logic [2:0] S_CMP  = 3'd2;
  localparam logic [2:0] S_SWAP = 3'd3;
  localparam logic [2:0] S_POLY = 3'd4;
  localparam logic [2:0] S_TRI  = 3'd5;
  localparam logic [2:0] S_DEC  = 3'd6;
  localparam logic [2:0] S_OUT  = 3'd7;

  // Operation codes
  localparam logic [OP_W-1:0] OP_NOP  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_CLR  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_CMP  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SWAP = OP_W'(3);
  localparam logic [OP_W-1:0] OP_POLY = OP_W'(4);
  localparam logic [OP_W-1:0] OP_TRI  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_DEC  = OP_W'(6);

  // Slot indices
  localparam logic [IDX_W-1:0] I0 = IDX_W'(0);
  localparam logic [IDX_W-1:0] I1 = IDX_W'(1);
  localparam logic [IDX_W-1:0] I2 = IDX_W'(2);
  localparam logic [IDX_W-1:0] I3 = IDX_W'(3);
  localparam logic [IDX_W-1:0] I5 = IDX_W'(5);
  localparam logic [IDX_W-1:0] I6 = IDX_W'(6);

  logic [2:0]       state_q,    state_d;
  logic             load_en_q,  load_en_d;
  logic [IDX_W-1:0] load_idx_q, load_idx_d;
  logic             op_valid_q, op_valid_d;
  logic [OP_W-1:0]  op_q,       op_d;
  logic [IDX_W-1:0] idx_a_q,    idx_a_d;
  logic [IDX_W-1:0] idx_b_q,    idx_b_d;
  logic             valid_q,    valid_d;
  logic             inside_q,   inside_d;

  logic             done_s;
  logic             sort_end_s;
  logic [IDX_W-1:0] sort_a_s, sort_b_s;
  logic             ring_last_s;
  logic [IDX_W-1:0] ring_a_s, ring_b_s;

  // A completion only counts while a request is actually pending
  assign done_s = op_valid_q & dp_done;

  // Next selection-sort pair after (idx_a, idx_b); after (5,6) the sort is over
  always_comb begin
    sort_a_s   = idx_a_q;
    sort_b_s   = idx_b_q;
    sort_end_s = 1'b0;
    if (idx_b_q < I6) begin
      sort_b_s = idx_b_q + I1;
    end else if (idx_a_q < I5) begin
      sort_a_s = idx_a_q + I1;
      sort_b_s = idx_a_q + I2;
    end else begin
      sort_end_s = 1'b1;
      sort_a_s   = I1;
      sort_b_s   = I2;
    end
  end

  // Next polygon edge (i, i mod 6 + 1); after (6,1) restart at (1,2) for the
  // following ring pass so the index flops never see 7
  always_comb begin
    ring_last_s = (idx_a_q == I6);
    if (ring_last_s) begin
      ring_a_s = I1;
      ring_b_s = I2;
    end else if (idx_a_q == I5) begin
      ring_a_s = I6;
      ring_b_s = I1;
    end else begin
      ring_a_s = idx_a_q + I1;
      ring_b_s = idx_a_q + I2;
    end
  end

  // Sequencer next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    load_en_d  = 1'b0;
    load_idx_d = I0;
    op_valid_d = op_valid_q;
    op_d       = op_q;
    idx_a_d    = idx_a_q;
    idx_b_d    = idx_b_q;
    valid_d    = 1'b0;
    inside_d   = inside_q;

    case (state_q)
      S_LOAD: begin
        op_valid_d = 1'b0;
        op_d       = OP_NOP;
        idx_a_d    = I0;
        idx_b_d    = I0;
        if (!load_en_q) begin
          // Coming out of reset: start the frame at slot 0
          load_en_d  = 1'b1;
          load_idx_d = I0;
        end else if (load_idx_q == I6) begin
          state_d    = S_CLR;
          op_valid_d = 1'b1;
          op_d       = OP_CLR;
        end else begin
          load_en_d  = 1'b1;
          load_idx_d = load_idx_q + I1;
        end
      end

      S_CLR: begin
        if (done_s) begin
          state_d = S_CMP;
          op_d    = OP_CMP;
          idx_a_d = I2;
          idx_b_d = I3;
        end else begin
          state_d = S_CLR;
        end
      end

      S_CMP: begin
        if (done_s && dp_flag) begin
          // Same pair, now swap it
          state_d = S_SWAP;
          op_d    = OP_SWAP;
        end else if (done_s && sort_end_s) begin
          state_d = S_POLY;
          op_d    = OP_POLY;
          idx_a_d = sort_a_s;
          idx_b_d = sort_b_s;
        end else if (done_s) begin
          idx_a_d = sort_a_s;
          idx_b_d = sort_b_s;
        end else begin
          state_d = S_CMP;
        end
      end

      S_SWAP: begin
        if (done_s && sort_end_s) begin
          state_d = S_POLY;
          op_d    = OP_POLY;
          idx_a_d = sort_a_s;
          idx_b_d = sort_b_s;
        end else if (done_s) begin
          state_d = S_CMP;
          op_d    = OP_CMP;
          idx_a_d = sort_a_s;
          idx_b_d = sort_b_s;
        end else begin
          state_d = S_SWAP;
        end
      end

      S_POLY: begin
        if (done_s && ring_last_s) begin
          state_d = S_TRI;
          op_d    = OP_TRI;
          idx_a_d = ring_a_s;
          idx_b_d = ring_b_s;
        end else if (done_s) begin
          idx_a_d = ring_a_s;
          idx_b_d = ring_b_s;
        end else begin
          state_d = S_POLY;
        end
      end

      S_TRI: begin
        if (done_s && ring_last_s) begin
          state_d = S_DEC;
          op_d    = OP_DEC;
          idx_a_d = I0;
          idx_b_d = I0;
        end else if (done_s) begin
          idx_a_d = ring_a_s;
          idx_b_d = ring_b_s;
        end else begin
          state_d = S_TRI;
        end
      end

      S_DEC: begin
        if (done_s) begin
          // Verdict and strobe land in the same cycle
          state_d    = S_OUT;
          op_valid_d = 1'b0;
          op_d       = OP_NOP;
          idx_a_d    = I0;
          idx_b_d    = I0;
          valid_d    = 1'b1;
          inside_d   = dp_flag;
        end else begin
          state_d = S_DEC;
        end
      end

      S_OUT: begin
        state_d    = S_LOAD;
        op_valid_d = 1'b0;
        op_d       = OP_NOP;
        idx_a_d    = I0;
        idx_b_d    = I0;
        load_en_d  = 1'b1;
        load_idx_d = I0;
      end

      default: begin
        state_d    = S_LOAD;
        op_valid_d = 1'b0;
        op_d       = OP_NOP;
        idx_a_d    = I0;
        idx_b_d    = I0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_LOAD;
      load_en_q  <= 1'b0;
      load_idx_q <= I0;
      op_valid_q <= 1'b0;
      op_q       <= OP_NOP;
      idx_a_q    <= I0;
      idx_b_q    <= I0;
      valid_q    <= 1'b0;
      inside_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_en_q  <= load_en_d;
      load_idx_q <= load_idx_d;
      op_valid_q <= op_valid_d;
      op_q       <= op_d;
      idx_a_q    <= idx_a_d;
      idx_b_q    <= idx_b_d;
      valid_q    <= valid_d;
      inside_q   <= inside_d;
    end
  end

  assign load_en   = load_en_q;
  assign load_idx  = load_idx_q;
  assign op_valid  = op_valid_q;
  assign op        = op_q;
  assign idx_a     = idx_a_q;
  assign idx_b     = idx_b_q;
  assign valid     = valid_q;
  assign is_inside = inside_q;

endmodule

// File: tb/tb_geofence_seq.sv
// Directed testbench for geofence_seq: walks whole frames cycle by cycle
// against an op list built here from the sequencing rules.
module tb_geofence_seq;

  logic       clk;
  logic       reset;
  logic       load_en;
  logic [2:0] load_idx;
  logic       op_valid;
  logic [2:0] op;
  logic [2:0] idx_a;
  logic [2:0] idx_b;
  logic       dp_done;
  logic       dp_flag;
  logic       valid;
  logic       is_inside;

  int n_vec;
  int n_err;

  geofence_seq #(.IDX_W(3), .OP_W(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .load_en  (load_en),
    .load_idx (load_idx),
    .op_valid (op_valid),
    .op       (op),
    .idx_a    (idx_a),
    .idx_b    (idx_b),
    .dp_done  (dp_done),
    .dp_flag  (dp_flag),
    .valid    (valid),
    .is_inside(is_inside)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".load_en"},   int'(load_en),   0);
    chk({tag, ".load_idx"},  int'(load_idx),  0);
    chk({tag, ".op_valid"},  int'(op_valid),  0);
    chk({tag, ".op"},        int'(op),        0);
    chk({tag, ".idx_a"},     int'(idx_a),     0);
    chk({tag, ".idx_b"},     int'(idx_b),     0);
    chk({tag, ".valid"},     int'(valid),     0);
    chk({tag, ".is_inside"}, int'(is_inside), 0);
  endtask

  // Walk one frame starting at the negedge of load cycle 0.
  // cmp_flag: dp_flag on every CMP; dec_flag: dp_flag on DECIDE;
  // (st_a,st_b,st_n): hold dp_done low st_n cycles on that CMP;
  // abort_poly: if nonzero, assert reset while POLY(abort_poly, ..) is pending.
  task automatic run_frame(input bit cmp_flag, input bit dec_flag, input bit prev_inside,
                           input int st_a, input int st_b, input int st_n,
                           input int abort_poly, input int exp_valid_cyc);
    int q_op[$];
    int q_a[$];
    int q_b[$];
    int t;
    int stalls;
    t = 0;
    // Load phase, with dp_done toggling to show it is ignored here
    for (int k = 0; k < 7; k++) begin
      chk("load.load_en",  int'(load_en),  1);
      chk("load.load_idx", int'(load_idx), k);
      chk("load.op_valid", int'(op_valid), 0);
      chk("load.valid",    int'(valid),    0);
      dp_done = k[0];
      dp_flag = 1'b1;
      @(negedge clk); t++;
    end
    // Expected op list
    q_op.push_back(1); q_a.push_back(0); q_b.push_back(0);
    for (int i = 2; i <= 5; i++) begin
      for (int j = i + 1; j <= 6; j++) begin
        q_op.push_back(2); q_a.push_back(i); q_b.push_back(j);
        if (cmp_flag) begin
          q_op.push_back(3); q_a.push_back(i); q_b.push_back(j);
        end
      end
    end
    for (int p = 5; p >= 4; p--) begin
      for (int i = 1; i <= 6; i++) begin
        q_op.push_back(p == 5 ? 4 : 5); q_a.push_back(i); q_b.push_back((i % 6) + 1);
      end
    end
    q_op.push_back(6); q_a.push_back(0); q_b.push_back(0);

    foreach (q_op[n]) begin
      stalls = (q_op[n] == 2 && q_a[n] == st_a && q_b[n] == st_b) ? st_n : 0;
      for (int s = 0; s <= stalls; s++) begin
        chk("op.op_valid",  int'(op_valid),  1);
        chk("op.load_en",   int'(load_en),   0);
        chk("op.op",        int'(op),        q_op[n]);
        chk("op.idx_a",     int'(idx_a),     q_a[n]);
        chk("op.idx_b",     int'(idx_b),     q_b[n]);
        chk("op.valid",     int'(valid),     0);
        chk("op.is_inside", int'(is_inside), int'(prev_inside));
        if (abort_poly != 0 && q_op[n] == 4 && q_a[n] == abort_poly) begin
          #2 reset = 1'b1;
          #1 chk_zero("abort.async");
          @(negedge clk);
          chk_zero("abort.held");
          reset = 1'b0;
          dp_done = 1'b1;
          @(negedge clk);
          return;
        end
        dp_done = (s == stalls);
        dp_flag = (q_op[n] == 2) ? cmp_flag : (q_op[n] == 6) ? dec_flag : 1'b0;
        @(negedge clk); t++;
      end
    end
    // Strobe cycle
    chk("out.cycle",     t, exp_valid_cyc);
    chk("out.valid",     int'(valid),     1);
    chk("out.is_inside", int'(is_inside), int'(dec_flag));
    chk("out.op_valid",  int'(op_valid),  0);
    chk("out.load_en",   int'(load_en),   0);
    dp_done = 1'b1;
    dp_flag = ~dec_flag;
    @(negedge clk); t++;
    // Next frame starts right after the strobe
    chk("next.valid",     int'(valid),     0);
    chk("next.is_inside", int'(is_inside), int'(dec_flag));
    chk("next.load_en",   int'(load_en),   1);
    chk("next.load_idx",  int'(load_idx),  0);
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    reset   = 1'b1;
    dp_done = 1'b0;
    dp_flag = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_zero("reset");
    reset   = 1'b0;
    dp_done = 1'b1;
    @(negedge clk);

    // Plain frame, no swaps, outside
    run_frame(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 31);
    // Every CMP swaps, inside
    run_frame(1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 41);
    // Five-cycle stall on CMP(3,5), inside held
    run_frame(1'b0, 1'b1, 1'b1, 3, 5, 5, 0, 36);
    // Verdict drops back to outside
    run_frame(1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 31);
    // Set inside, then abort mid-POLY(4,5) with reset
    run_frame(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 31);
    run_frame(1'b0, 1'b0, 1'b1, 0, 0, 0, 4, 0);
    // Fresh frame after the abort; verdict was cleared by reset
    run_frame(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 31);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
